// File: rtl/div_share_arbiter_pkg.sv
// ============================================================================
// Module   : div_arb_pkg
// Brief    : Shared types, constants and the round-robin pick function used by
//            the divider-sharing arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_arb_pkg;

    // Default operand/result width in bits
    localparam int c_DEF_WIDTH = 32;

    // Widest request vector rr_pick can search
    localparam int c_MAX_REQ = 32;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // First set bit of valid searching ptr, ptr+1, ..., n-1, 0, ... (wraps).
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [31:0] rr_pick(
        input logic [c_MAX_REQ-1:0] valid,
        input logic [31:0]          ptr,
        input logic [31:0]          n
    );
        logic [31:0] idx;
        logic        found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            idx = ptr + 32'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (32'(k) < n) && valid[idx[4:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_share_arbiter_if.sv
// ============================================================================
// Module   : div_share_arbiter_if
// Brief    : Client request/response and divider-side signals of the shared
//            divider arbiter. slave = arbiter, master = clients + divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_share_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int tamanyo = c_DEF_WIDTH,
    parameter int N_REQ   = 4
) ();

    // Client request side
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*tamanyo-1:0] req_num;
    logic [N_REQ*tamanyo-1:0] req_den;
    logic [N_REQ-1:0]         req_ready;

    // Client response side
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ-1:0]         rsp_ready;
    logic [tamanyo-1:0]       rsp_coc;
    logic [tamanyo-1:0]       rsp_res;
    logic                     rsp_dz;

    // Divider side
    logic                     div_start;
    logic [tamanyo-1:0]       div_num;
    logic [tamanyo-1:0]       div_den;
    logic [tamanyo-1:0]       div_coc;
    logic [tamanyo-1:0]       div_res;
    logic                     div_done;

    modport slave (
        input  req_valid, req_num, req_den, rsp_ready, div_coc, div_res, div_done,
        output req_ready, rsp_valid, rsp_coc, rsp_res, rsp_dz, div_start, div_num, div_den
    );

    modport master (
        output req_valid, req_num, req_den, rsp_ready, div_coc, div_res, div_done,
        input  req_ready, rsp_valid, rsp_coc, rsp_res, rsp_dz, div_start, div_num, div_den
    );

endinterface

`default_nettype wire

// File: rtl/div_share_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker: request vector + priority
//            pointer -> one-hot grant, grant index and any-request flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW   = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [PW-1:0]    i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [PW-1:0]    o_idx,
    output logic                  o_any
);

    logic [c_MAX_REQ-1:0] w_req_ext;

    assign w_req_ext = c_MAX_REQ'(i_req);
    assign o_any     = |i_req;
    assign o_idx     = PW'(rr_pick(w_req_ext, 32'(i_ptr), 32'(N_REQ)));

    // One-hot grant of the picked index, empty when nobody is requesting
    always_comb begin
        o_grant = '0;
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_share_arbiter.sv
// ============================================================================
// Module   : div_share_arbiter
// Brief    : Shares one multicycle signed divider among N_REQ requesters with
//            round-robin grant, one division in flight at a time, and a
//            per-requester valid/ready response.
//            Optional macro DIV_ZERO_GUARD_EN: zero divisors are answered
//            locally (coc=all ones, res=num, rsp_dz=1) without the divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int tamanyo = c_DEF_WIDTH,
    parameter int N_REQ   = 4
) (
    input wire logic          CLK,
    input wire logic          RSTa,
    div_share_arbiter_if.slave bus
);

    localparam int              c_PW   = $clog2(N_REQ);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(N_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;

    logic [c_PW-1:0]    r_ptr;
    logic [c_PW-1:0]    r_gidx;
    logic [tamanyo-1:0] r_num;
    logic [tamanyo-1:0] r_den;
    logic [tamanyo-1:0] r_coc;
    logic [tamanyo-1:0] r_res;

    logic [N_REQ-1:0]   w_grant;
    logic [c_PW-1:0]    w_idx;
    logic               w_any;
    logic               w_hs;
    logic [tamanyo-1:0] w_sel_num;
    logic [tamanyo-1:0] w_sel_den;

`ifdef DIV_ZERO_GUARD_EN
    logic               r_dz;
    logic               w_den_zero;
    assign w_den_zero = ~|w_sel_den;
`endif

    rr_arbiter #(
        .N_REQ   (N_REQ)
    ) u_rr (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Operands of the requester the picker currently points at
    assign w_sel_num = bus.req_num[w_idx*tamanyo +: tamanyo];
    assign w_sel_den = bus.req_den[w_idx*tamanyo +: tamanyo];

    // req_ready mirrors the grant, so any valid request in IDLE is a handshake
    assign w_hs = (r_state == IDLE) && w_any;

    // State register; reset discards whatever was in flight
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.div_start = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = w_grant;
                if (w_any) begin
`ifdef DIV_ZERO_GUARD_EN
                    w_state_nxt = w_den_zero ? RESP : ISSUE;
`else
                    w_state_nxt = ISSUE;
`endif
                end
            end
            ISSUE: begin
                bus.div_start = 1'b1;
                w_state_nxt   = WAIT;
            end
            WAIT: begin
                if (bus.div_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[r_gidx] = 1'b1;
                if (bus.rsp_ready[r_gidx]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latches, result capture and round-robin pointer update
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            r_ptr  <= '0;
            r_gidx <= '0;
            r_num  <= '0;
            r_den  <= '0;
            r_coc  <= '0;
            r_res  <= '0;
`ifdef DIV_ZERO_GUARD_EN
            r_dz   <= 1'b0;
`endif
        end else begin
            if (w_hs) begin
                r_num  <= w_sel_num;
                r_den  <= w_sel_den;
                r_gidx <= w_idx;
`ifdef DIV_ZERO_GUARD_EN
                r_dz   <= w_den_zero;
                if (w_den_zero) begin
                    r_coc <= '1;
                    r_res <= w_sel_num;
                end
`endif
            end
            if ((r_state == WAIT) && bus.div_done) begin
                r_coc <= bus.div_coc;
                r_res <= bus.div_res;
            end
            if ((r_state == RESP) && bus.rsp_ready[r_gidx]) begin
                r_ptr <= (r_gidx == c_LAST) ? '0 : r_gidx + c_PW'(1);
            end
        end
    end

    assign bus.div_num = r_num;
    assign bus.div_den = r_den;
    assign bus.rsp_coc = r_coc;
    assign bus.rsp_res = r_res;
`ifdef DIV_ZERO_GUARD_EN
    assign bus.rsp_dz  = r_dz;
`else
    assign bus.rsp_dz  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
// ============================================================================
// Module   : tb_div_share_arbiter
// Brief    : Self-checking bench for div_share_arbiter (tamanyo=32, N_REQ=3)
//            with a behavioural signed divider attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_share_arbiter;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int LAT = 12;

    logic CLK  = 1'b0;
    logic RSTa = 1'b0;

    always #5 CLK = ~CLK;

    div_share_arbiter_if #(.tamanyo(W), .N_REQ(N)) bus ();

    div_share_arbiter #(.tamanyo(W), .N_REQ(N)) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] coc;
        logic [31:0] res;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural divider: fixed latency, done pulse, results held afterwards
    logic        m_busy, m_done, stray_done;
    int          m_cnt;
    logic [31:0] m_n, m_d, m_coc, m_res;

    assign bus.div_done = m_done | stray_done;
    assign bus.div_coc  = stray_done ? 32'hDEAD_BEEF : m_coc;
    assign bus.div_res  = stray_done ? 32'hBAD0_BAD0 : m_res;

    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
            m_n <= '0; m_d <= '0; m_coc <= '0; m_res <= '0;
        end else begin
            m_done <= 1'b0;
            if (bus.div_start) begin
                m_busy <= 1'b1; m_cnt <= LAT; m_n <= bus.div_num; m_d <= bus.div_den;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_coc  <= (m_d == 0) ? 32'hFFFF_FFFF : 32'($signed(m_n) / $signed(m_d));
                    m_res  <= (m_d == 0) ? m_n : 32'($signed(m_n) % $signed(m_d));
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Start counter and "start while a division is outstanding" detector
    int   start_cnt = 0;
    int   overlap   = 0;
    logic outstanding = 1'b0;

    always @(negedge CLK) begin
        if (!RSTa) begin
            outstanding <= 1'b0;
        end else if (bus.div_start) begin
            start_cnt   <= start_cnt + 1;
            if (outstanding) overlap <= overlap + 1;
            outstanding <= 1'b1;
        end else if (|(bus.rsp_valid & bus.rsp_ready)) begin
            outstanding <= 1'b0;
        end
    end

    function automatic exp_t model(int id, logic [31:0] n, logic [31:0] d);
        exp_t e;
        e.id = id;
        if (d == 0) begin
            e.coc = 32'hFFFF_FFFF; e.res = n; e.dz = 1'b1;
        end else begin
            e.coc = 32'($signed(n) / $signed(d));
            e.res = 32'($signed(n) % $signed(d));
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(int id, logic [31:0] n, logic [31:0] d);
        sb.push_back(model(id, n, d));
    endtask

    task automatic pop_exp(input int id, output exp_t e, output bit found);
        found = 1'b0;
        e.id = -1; e.coc = 'x; e.res = 'x; e.dz = 1'bx;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].id == id) begin
                e = sb[k];
                sb.delete(k);
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_req(int id, logic [31:0] n, logic [31:0] d);
        bus.req_num[id*W +: W] = n;
        bus.req_den[id*W +: W] = d;
        bus.req_valid[id]      = 1'b1;
        push_exp(id, n, d);
    endtask

    // Returns at the negedge of the handshake cycle
    task automatic wait_grant(output int idx, output bit ok);
        ok = 1'b0; idx = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (|(bus.req_valid & bus.req_ready)) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) idx = i;
                end
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL grant_timeout got=no_handshake expected=handshake");
        end
    endtask

    task automatic wait_rsp(input int id, input bit accept,
                            output logic [31:0] c, output logic [31:0] r,
                            output logic dz, output bit ok);
        ok = 1'b0; c = 'x; r = 'x; dz = 1'bx;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid[id]) begin
                c = bus.rsp_coc; r = bus.rsp_res; dz = bus.rsp_dz; ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL rsp_timeout id=%0d got=no_rsp_valid expected=rsp_valid", id);
        end else if (accept) begin
            @(posedge CLK); #1 bus.rsp_ready[id] = 1'b1;
            @(posedge CLK); #1 bus.rsp_ready[id] = 1'b0;
        end
    endtask

    task automatic test_reset();
        RSTa = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.req_ready !== 3'b000 || bus.rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL reset_hs got ready=%b rsp_valid=%b expected 000/000", bus.req_ready, bus.rsp_valid);
        end
        checks++;
        if (bus.div_start !== 1'b0) begin
            failures++; $display("FAIL reset_start got=%b expected=0", bus.div_start);
        end
        checks++;
        if (bus.div_num !== 32'd0 || bus.div_den !== 32'd0) begin
            failures++; $display("FAIL reset_div_ops got num=%h den=%h expected 0/0", bus.div_num, bus.div_den);
        end
        checks++;
        if (bus.rsp_coc !== 32'd0 || bus.rsp_res !== 32'd0) begin
            failures++; $display("FAIL reset_rsp got coc=%h res=%h expected 0/0", bus.rsp_coc, bus.rsp_res);
        end
        checks++;
        if (bus.rsp_dz !== 1'b0) begin
            failures++; $display("FAIL reset_dz got=%b expected=0", bus.rsp_dz);
        end
        @(posedge CLK); #1 RSTa = 1'b1;
    endtask

    task automatic test_all_valid();
        logic [31:0] nums[N];
        logic [31:0] dens[N];
        int order[4] = '{0, 1, 2, 0};
        int idx; bit ok, f;
        logic [31:0] c, r; logic dz; exp_t e;
        for (int i = 0; i < N; i++) begin
            nums[i] = 32'(60 + 10 * i);
            dens[i] = 32'(3 + i);
            bus.req_num[i*W +: W] = nums[i];
            bus.req_den[i*W +: W] = dens[i];
        end
        bus.req_valid = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_grant(idx, ok);
            if (!ok) return;
            checks++;
            if (idx != order[g]) begin
                failures++; $display("FAIL all_valid_order step=%0d got=%0d expected=%0d", g, idx, order[g]);
            end
            push_exp(idx, nums[idx], dens[idx]);
            if (g == 3) begin
                @(posedge CLK); #1 bus.req_valid = 3'b000;
            end
            wait_rsp(idx, 1'b1, c, r, dz, ok);
            pop_exp(idx, e, f);
            checks++;
            if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
                failures++;
                $display("FAIL sb_all_valid id=%0d got coc=%0d res=%0d dz=%b expected coc=%0d res=%0d dz=%b",
                         idx, $signed(c), $signed(r), dz, $signed(e.coc), $signed(e.res), e.dz);
            end
        end
        checks++;
        if (overlap != 0) begin
            failures++; $display("FAIL all_valid_overlap got=%0d expected=0", overlap);
        end
    endtask

    task automatic test_single();
        int s0, idx; bit ok, f;
        logic [31:0] c, r; logic dz; exp_t e;
        s0 = start_cnt;
        drive_req(0, 32'd100, 32'd7);
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 3'b001) begin
            failures++; $display("FAIL single_ready got=%b expected=001", bus.req_ready);
        end
        @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
        wait_rsp(0, 1'b1, c, r, dz, ok);
        checks++;
        if (c !== 32'd14 || r !== 32'd2) begin
            failures++; $display("FAIL single_result got coc=%0d res=%0d expected coc=14 res=2", c, r);
        end
        pop_exp(0, e, f);
        checks++;
        if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
            failures++; $display("FAIL sb_single got coc=%0d res=%0d dz=%b expected coc=%0d res=%0d dz=%b",
                                 c, r, dz, e.coc, e.res, e.dz);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++; $display("FAIL single_starts got=%0d expected=1", start_cnt - s0);
        end
        // ptr is now 1: with 0 and 1 both pending, 1 goes first
        drive_req(0, 32'd20, 32'd4);
        drive_req(1, 32'd21, 32'd5);
        for (int g = 0; g < 2; g++) begin
            wait_grant(idx, ok);
            if (!ok) return;
            checks++;
            if (idx != 1 - g) begin
                failures++; $display("FAIL ptr_order step=%0d got=%0d expected=%0d", g, idx, 1 - g);
            end
            @(posedge CLK); #1 bus.req_valid[idx] = 1'b0;
            wait_rsp(idx, 1'b1, c, r, dz, ok);
            pop_exp(idx, e, f);
            checks++;
            if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
                failures++; $display("FAIL sb_ptr id=%0d got coc=%0d res=%0d expected coc=%0d res=%0d",
                                     idx, c, r, e.coc, e.res);
            end
        end
    endtask

    task automatic test_signs();
        logic [31:0] tn[3], td[3], tc[3], tr[3];
        int idx; bit ok, f;
        logic [31:0] c, r; logic dz; exp_t e;
        tn = '{-32'sd7, 32'sd7, -32'sd7};
        td = '{32'sd2, -32'sd2, -32'sd2};
        tc = '{-32'sd3, -32'sd3, 32'sd3};
        tr = '{-32'sd1, 32'sd1, -32'sd1};
        for (int t = 0; t < 3; t++) begin
            drive_req(2, tn[t], td[t]);
            wait_grant(idx, ok);
            if (!ok) return;
            @(posedge CLK); #1 bus.req_valid[2] = 1'b0;
            wait_rsp(2, 1'b1, c, r, dz, ok);
            checks++;
            if (c !== tc[t] || r !== tr[t]) begin
                failures++; $display("FAIL signs case=%0d got coc=%0d res=%0d expected coc=%0d res=%0d",
                                     t, $signed(c), $signed(r), $signed(tc[t]), $signed(tr[t]));
            end
            pop_exp(2, e, f);
            checks++;
            if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
                failures++; $display("FAIL sb_signs case=%0d got coc=%0d res=%0d expected coc=%0d res=%0d",
                                     t, $signed(c), $signed(r), $signed(e.coc), $signed(e.res));
            end
        end
    endtask

    task automatic test_backpressure();
        int idx, bad, bad_start, bad_rdy; bit ok, f;
        logic [31:0] c, r, c2, r2; logic dz, dz2; exp_t e;
        bad = 0; bad_start = 0; bad_rdy = 0;
        drive_req(1, 32'd50, 32'd6);
        wait_grant(idx, ok);
        if (!ok) return;
        @(posedge CLK); #1 bus.req_valid[1] = 1'b0;
        wait_rsp(1, 1'b0, c, r, dz, ok);
        if (!ok) return;
        // Competing request plus a ready on a non-granted index while held
        @(posedge CLK); #1;
        drive_req(0, 32'd77, 32'd7);
        bus.rsp_ready[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.rsp_valid !== 3'b010 || bus.rsp_coc !== c || bus.rsp_res !== r) bad++;
            if (bus.div_start !== 1'b0) bad_start++;
            if (bus.req_ready !== 3'b000) bad_rdy++;
            stray_done = (k == 5);
        end
        stray_done = 1'b0;
        bus.rsp_ready[0] = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_stable got_bad_cycles=%0d expected=0", bad);
        end
        checks++;
        if (bad_start != 0) begin
            failures++; $display("FAIL bp_no_start got=%0d expected=0", bad_start);
        end
        checks++;
        if (bad_rdy != 0) begin
            failures++; $display("FAIL bp_ready_low got=%0d expected=0", bad_rdy);
        end
        checks++;
        if (c !== 32'd8 || r !== 32'd2) begin
            failures++; $display("FAIL bp_result got coc=%0d res=%0d expected coc=8 res=2", c, r);
        end
        // Response accepted while req 0 waits: grant comes one cycle later
        @(posedge CLK); #1 bus.rsp_ready[1] = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 3'b000) begin
            failures++; $display("FAIL same_cycle_grant got=%b expected=000", bus.req_ready);
        end
        @(posedge CLK); #1 bus.rsp_ready[1] = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 3'b001) begin
            failures++; $display("FAIL next_cycle_grant got=%b expected=001", bus.req_ready);
        end
        pop_exp(1, e, f);
        checks++;
        if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
            failures++; $display("FAIL sb_bp got coc=%0d res=%0d expected coc=%0d res=%0d", c, r, e.coc, e.res);
        end
        @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
        wait_rsp(0, 1'b1, c2, r2, dz2, ok);
        pop_exp(0, e, f);
        checks++;
        if (!f || c2 !== e.coc || r2 !== e.res || dz2 !== e.dz) begin
            failures++; $display("FAIL sb_bp_next got coc=%0d res=%0d expected coc=%0d res=%0d", c2, r2, e.coc, e.res);
        end
    endtask

    task automatic test_reset_mid();
        int idx; bit ok, f, seen;
        logic [31:0] c, r; logic dz; exp_t e;
        drive_req(2, 32'd1000, 32'd3);
        wait_grant(idx, ok);
        if (!ok) return;
        @(posedge CLK); #1 bus.req_valid[2] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.div_start) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rst_mid_start got=no_start expected=start");
        end
        repeat (3) @(posedge CLK);
        #1 RSTa = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 3'b000 || bus.rsp_valid !== 3'b000 || bus.div_start !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ctrl got ready=%b rsp_valid=%b start=%b expected 0",
                                 bus.req_ready, bus.rsp_valid, bus.div_start);
        end
        checks++;
        if (bus.div_num !== 32'd0 || bus.div_den !== 32'd0 || bus.rsp_coc !== 32'd0 ||
            bus.rsp_res !== 32'd0 || bus.rsp_dz !== 1'b0) begin
            failures++; $display("FAIL rst_mid_data got num=%h den=%h coc=%h res=%h dz=%b expected 0",
                                 bus.div_num, bus.div_den, bus.rsp_coc, bus.rsp_res, bus.rsp_dz);
        end
        pop_exp(2, e, f);
        repeat (2) @(posedge CLK);
        #1 RSTa = 1'b1;
        @(posedge CLK); #1;
        drive_req(0, 32'd9, 32'd3);
        wait_grant(idx, ok);
        if (!ok) return;
        @(posedge CLK); #1 bus.req_valid[0] = 1'b0;
        wait_rsp(0, 1'b1, c, r, dz, ok);
        checks++;
        if (c !== 32'd3 || r !== 32'd0) begin
            failures++; $display("FAIL rst_mid_after got coc=%0d res=%0d expected coc=3 res=0", c, r);
        end
        pop_exp(0, e, f);
        checks++;
        if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
            failures++; $display("FAIL sb_rst_mid got coc=%0d res=%0d dz=%b expected coc=%0d res=%0d dz=%b",
                                 c, r, dz, e.coc, e.res, e.dz);
        end
    endtask

`ifdef DIV_ZERO_GUARD_EN
    task automatic test_dz();
        int s0, idx, lat; bit ok, f;
        logic [31:0] c, r; logic dz; exp_t e;
        s0 = start_cnt;
        drive_req(1, 32'd5, 32'd0);
        wait_grant(idx, ok);
        if (!ok) return;
        @(posedge CLK); #1 bus.req_valid[1] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 2; k++) begin
            if (k > 1) begin @(posedge CLK); #1; end
            @(negedge CLK);
            if (bus.rsp_valid[1] && lat < 0) lat = k;
        end
        checks++;
        if (lat < 0) begin
            failures++; $display("FAIL dz_latency got=no_rsp expected=rsp_within_2_cycles");
        end
        wait_rsp(1, 1'b1, c, r, dz, ok);
        checks++;
        if (dz !== 1'b1 || c !== 32'hFFFF_FFFF || r !== 32'd5) begin
            failures++; $display("FAIL dz_result got dz=%b coc=%h res=%0d expected dz=1 coc=ffffffff res=5", dz, c, r);
        end
        pop_exp(1, e, f);
        checks++;
        if (!f || c !== e.coc || r !== e.res || dz !== e.dz) begin
            failures++; $display("FAIL sb_dz got coc=%h res=%0d expected coc=%h res=%0d", c, r, e.coc, e.res);
        end
        checks++;
        if (start_cnt != s0) begin
            failures++; $display("FAIL dz_no_start got=%0d expected=0", start_cnt - s0);
        end
    endtask
`endif

    initial begin
        bus.req_valid = '0;
        bus.req_num   = '0;
        bus.req_den   = '0;
        bus.rsp_ready = '0;
        stray_done    = 1'b0;
        test_reset();
        test_all_valid();
        test_single();
        test_signs();
        test_backpressure();
        test_reset_mid();
`ifdef DIV_ZERO_GUARD_EN
        test_dz();
`endif
        checks++;
        if (overlap != 0) begin
            failures++; $display("FAIL start_overlap got=%0d expected=0", overlap);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
